// File: rtl/output_mem_pkg.sv
// Shared types and defaults for the multi-channel output memory.
// Mode encodings, FSM states and the mode-to-state mapping.
package output_mem_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int ADDR_W_DEF = 7;
    localparam int DEPTH_DEF  = 128;
    localparam int NUM_CH_DEF = 2;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'b00,
        MODE_SCAN_IN  = 2'b01,
        MODE_RUN      = 2'b10,
        MODE_SCAN_OUT = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_IN,
        ST_SCAN_OUT,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic state_e mode_state(input mode_e m);
        state_e s;
        case (m)
            MODE_SCAN_IN:  s = ST_SCAN_IN;
            MODE_RUN:      s = ST_RUN;
            MODE_SCAN_OUT: s = ST_SCAN_OUT;
            default:       s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/output_mem_bank.sv
// NUM_CH-write / NUM_CH-read register array.
// Lowest channel wins on write collisions; reads see same-cycle writes.
module output_mem_bank
    import output_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic                     clk,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     conflict
);

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Descending order so the lowest channel's assignment lands last.
    always_ff @(posedge clk) begin
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (wr_en[c] && in_range(wr_addr[c*ADDR_W +: ADDR_W])) begin
                mem[wr_addr[c*ADDR_W +: ADDR_W]] <=
                    wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_CH; r++) begin
            if (in_range(rd_addr[r*ADDR_W +: ADDR_W])) begin
                rd_data[r*DATA_W +: DATA_W] =
                    mem[rd_addr[r*ADDR_W +: ADDR_W]];
                for (int c = NUM_CH - 1; c >= 0; c--) begin
                    if (wr_en[c] &&
                        wr_addr[c*ADDR_W +: ADDR_W] ==
                        rd_addr[r*ADDR_W +: ADDR_W]) begin
                        rd_data[r*DATA_W +: DATA_W] =
                            wr_data[c*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int d = c + 1; d < NUM_CH; d++) begin
                if (wr_en[c] && wr_en[d] &&
                    wr_addr[c*ADDR_W +: ADDR_W] ==
                    wr_addr[d*ADDR_W +: ADDR_W] &&
                    in_range(wr_addr[c*ADDR_W +: ADDR_W])) begin
                    conflict = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/output_mem_mc.sv
// Single-clock N-channel output buffer: mode FSM, scan sequencing
// with a one-word output slot, and the RUN read pipeline.
module output_mem_mc
    import output_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode_i,
    input  logic                     scan_valid_i,
    input  logic [DATA_W-1:0]        scan_data_i,
    input  logic                     scan_ready_i,
    output logic                     scan_valid_o,
    output logic [DATA_W-1:0]        scan_data_o,
    output logic                     scan_done_o,
    input  logic [NUM_CH-1:0]        pe_valid_i,
    input  logic [NUM_CH*ADDR_W-1:0] pe_addr_i,
    input  logic [NUM_CH-1:0]        cim_wr_valid_i,
    input  logic [NUM_CH*ADDR_W-1:0] cim_wr_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] cim_wr_data_i,
    output logic [NUM_CH-1:0]        cim_rd_valid_o,
    output logic [NUM_CH*ADDR_W-1:0] cim_rd_addr_o,
    output logic [NUM_CH*DATA_W-1:0] cim_rd_data_o,
    output logic                     wr_conflict_o
);

    localparam int CNT_W = ADDR_W + 1;

    mode_e            mode_cur;
    mode_e            mode_q;
    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             slot_last;

    logic si_act;
    logic so_act;
    logic run_act;
    logic cnt_last;
    logic so_issue;
    logic so_accept;
    logic enter_scan;

    logic [NUM_CH-1:0]        bk_wr_en;
    logic [NUM_CH*ADDR_W-1:0] bk_wr_addr;
    logic [NUM_CH*DATA_W-1:0] bk_wr_data;
    logic [NUM_CH*ADDR_W-1:0] bk_rd_addr;
    logic [NUM_CH*DATA_W-1:0] bk_rd_data;
    logic                     bk_conflict;

    assign mode_cur = mode_e'(mode_i);

    // Activity requires the mode to still match, so a mode change
    // suppresses work on the cycle it is seen.
    assign si_act  = (state == ST_SCAN_IN)  && (mode_cur == MODE_SCAN_IN);
    assign so_act  = (state == ST_SCAN_OUT) && (mode_cur == MODE_SCAN_OUT);
    assign run_act = (state == ST_RUN)      && (mode_cur == MODE_RUN);

    assign cnt_last  = (cnt == CNT_W'(DEPTH - 1));
    assign so_accept = scan_valid_o && scan_ready_i;
    assign so_issue  = so_act && (32'(cnt) < DEPTH) &&
                       (!scan_valid_o || scan_ready_i);

    always_comb begin
        scan_done_o = (si_act && scan_valid_i && cnt_last) ||
                      (so_act && so_accept && slot_last);
        state_nxt = mode_state(mode_cur);
        if (state == ST_DONE && mode_cur == mode_q) begin
            state_nxt = ST_DONE;
        end
        if (scan_done_o) begin
            state_nxt = ST_DONE;
        end
        enter_scan = (state_nxt != state) &&
                     (state_nxt == ST_SCAN_IN ||
                      state_nxt == ST_SCAN_OUT);
    end

    // Channel 0 ports double as the scan write/read path.
    always_comb begin
        bk_wr_en   = '0;
        bk_wr_addr = cim_wr_addr_i;
        bk_wr_data = cim_wr_data_i;
        bk_rd_addr = pe_addr_i;
        if (si_act) begin
            bk_wr_en[0]              = scan_valid_i;
            bk_wr_addr[ADDR_W-1:0]   = cnt[ADDR_W-1:0];
            bk_wr_data[DATA_W-1:0]   = scan_data_i;
        end
        if (run_act) begin
            bk_wr_en = cim_wr_valid_i;
        end
        if (so_act) begin
            bk_rd_addr[ADDR_W-1:0] = cnt[ADDR_W-1:0];
        end
    end

    output_mem_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) u_bank (
        .clk      (clk),
        .wr_en    (bk_wr_en),
        .wr_addr  (bk_wr_addr),
        .wr_data  (bk_wr_data),
        .rd_addr  (bk_rd_addr),
        .rd_data  (bk_rd_data),
        .conflict (bk_conflict)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_IDLE;
        end else begin
            state  <= state_nxt;
            mode_q <= mode_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            scan_valid_o <= 1'b0;
            scan_data_o  <= '0;
            slot_last    <= 1'b0;
        end else begin
            if (enter_scan) begin
                cnt <= '0;
            end else if ((si_act && scan_valid_i) || so_issue) begin
                cnt <= cnt + 1'b1;
            end
            if (!so_act) begin
                scan_valid_o <= 1'b0;
            end else if (so_issue) begin
                scan_valid_o <= 1'b1;
                scan_data_o  <= bk_rd_data[DATA_W-1:0];
                slot_last    <= cnt_last;
            end else if (so_accept) begin
                scan_valid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cim_rd_valid_o <= '0;
            cim_rd_addr_o  <= '0;
            cim_rd_data_o  <= '0;
            wr_conflict_o  <= 1'b0;
        end else begin
            cim_rd_valid_o <= run_act ? pe_valid_i : '0;
            wr_conflict_o  <= run_act && bk_conflict;
            if (run_act) begin
                cim_rd_addr_o <= pe_addr_i;
                cim_rd_data_o <= bk_rd_data;
            end
        end
    end

endmodule
